// File: rtl/instruction_fetch_tr_if.sv
// Instruction fetch bus: load port, start control, instruction stream and status.
interface instruction_fetch_tr_if #(
  parameter int unsigned ADDR_W = 4
);
  logic              start;
  logic              ld_en;
  logic [ADDR_W-1:0] ld_addr;
  logic [31:0]       ld_data;
  logic              ready_in;
  logic [31:0]       Instruccion_TR;
  logic              valid_out;
  logic [31:0]       pc_out;
  logic [15:0]       instr_count;
  logic              busy;
  logic              done;

  // Fetch stage side: produces the instruction stream and status.
  modport master (
    input  start, ld_en, ld_addr, ld_data, ready_in,
    output Instruccion_TR, valid_out, pc_out, instr_count, busy, done
  );

  // Controller / datapath side: loads, starts and consumes.
  modport slave (
    output start, ld_en, ld_addr, ld_data, ready_in,
    input  Instruccion_TR, valid_out, pc_out, instr_count, busy, done
  );
endinterface

// File: rtl/instruction_fetch_tr.sv
// Instruction fetch stage: loadable instruction memory, PC, valid/ready output
// register, halt-sentinel detection and run statistics.
module instruction_fetch_tr #(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned ADDR_W    = 4,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic                   CLK,
  input  logic                   RST,
  instruction_fetch_tr_if.master bus
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   instr_q, instr_d;
  logic                valid_q, valid_d;
  logic [DATA_W-1:0]   pc_q, pc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [ADDR_W-1:0]   pc_idx;
  logic [ADDR_W-1:0]   pc_idx_nxt;
  logic [DATA_W-1:0]   rd_word;
  logic                slot_free;

  // Word index of the PC and its successor; the successor wraps modulo DEPTH.
  assign pc_idx     = pc_q[ADDR_W+1:2];
  assign pc_idx_nxt = ADDR_W'(pc_idx + ADDR_W'(1));
  assign rd_word    = mem_q[pc_idx];
  assign slot_free  = !valid_q || bus.ready_in;

  // Instruction memory: written only while idle, never reset.
  always_ff @(posedge CLK) begin
    if (state_q == IDLE && bus.ld_en) begin
      mem_q[bus.ld_addr] <= bus.ld_data;
    end
  end

  // State and output registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      instr_q <= '0;
      valid_q <= 1'b0;
      pc_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state, fetch and accounting logic.
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    valid_d = valid_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;

    if (valid_q && bus.ready_in && cnt_q != {CNT_W{1'b1}}) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          pc_d    = '0;
          cnt_d   = '0;
          valid_d = 1'b0;
        end
      end
      RUN: begin
        if (slot_free) begin
          if (rd_word != HALT_WORD) begin
            instr_d = rd_word;
            valid_d = 1'b1;
            pc_d    = DATA_W'({pc_idx_nxt, 2'b00});
          end else begin
            valid_d = 1'b0;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  assign bus.Instruccion_TR = instr_q;
  assign bus.valid_out      = valid_q;
  assign bus.pc_out         = pc_q;
  assign bus.instr_count    = cnt_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;

endmodule

// File: tb/tb_instruction_fetch_tr.sv
// Directed bench for instruction_fetch_tr: per-cycle vector table plus
// hand-written empty-program, wrap-around and async-reset sequences.
module tb_instruction_fetch_tr;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;
  localparam logic [31:0] W0   = 32'h0131_3820;
  localparam logic [31:0] W1   = 32'h0135_4820;

  logic CLK;
  logic RST;

  instruction_fetch_tr_if #(.ADDR_W(4)) bus ();

  instruction_fetch_tr #(
    .DEPTH    (16),
    .ADDR_W   (4),
    .HALT_WORD(HALT)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        start;
    logic        ld_en;
    logic [3:0]  ld_addr;
    logic [31:0] ld_data;
    logic        ready;
    logic [31:0] e_instr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [15:0] e_cnt;
    logic        e_busy;
    logic        e_done;
  } vec_t;

  localparam int NV = 18;
  vec_t vt [NV];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_all(input string nm, input logic [31:0] instr, input logic valid,
                         input logic [31:0] pc, input logic [15:0] cnt,
                         input logic busy, input logic done);
    chk({nm, ".instr"}, bus.Instruccion_TR, instr);
    chk({nm, ".valid"}, 32'(bus.valid_out), 32'(valid));
    chk({nm, ".pc"},    bus.pc_out, pc);
    chk({nm, ".cnt"},   32'(bus.instr_count), 32'(cnt));
    chk({nm, ".busy"},  32'(bus.busy), 32'(busy));
    chk({nm, ".done"},  32'(bus.done), 32'(done));
  endtask

  task automatic load(input logic [3:0] a, input logic [31:0] d);
    bus.ld_en   = 1'b1;
    bus.ld_addr = a;
    bus.ld_data = d;
    step();
    bus.ld_en   = 1'b0;
  endtask

  initial begin
    // start ld ldaddr lddata ready | instr valid pc cnt busy done
    vt[0]  = '{1'b0, 1'b1, 4'd0, W0,    1'b0, 32'h0, 1'b0, 32'd0, 16'd0, 1'b0, 1'b0};
    vt[1]  = '{1'b0, 1'b1, 4'd1, W1,    1'b0, 32'h0, 1'b0, 32'd0, 16'd0, 1'b0, 1'b0};
    vt[2]  = '{1'b0, 1'b1, 4'd2, HALT,  1'b0, 32'h0, 1'b0, 32'd0, 16'd0, 1'b0, 1'b0};
    vt[3]  = '{1'b1, 1'b0, 4'd0, 32'h0, 1'b1, 32'h0, 1'b0, 32'd0, 16'd0, 1'b1, 1'b0};
    vt[4]  = '{1'b0, 1'b0, 4'd0, 32'h0, 1'b1, W0,    1'b1, 32'd4, 16'd0, 1'b1, 1'b0};
    vt[5]  = '{1'b0, 1'b0, 4'd0, 32'h0, 1'b1, W1,    1'b1, 32'd8, 16'd1, 1'b1, 1'b0};
    vt[6]  = '{1'b0, 1'b0, 4'd0, 32'h0, 1'b1, W1,    1'b0, 32'd8, 16'd2, 1'b0, 1'b1};
    vt[7]  = '{1'b0, 1'b0, 4'd0, 32'h0, 1'b1, W1,    1'b0, 32'd8, 16'd2, 1'b0, 1'b0};
    // backpressure run, with ignored ld_en/start pulses while stalled
    vt[8]  = '{1'b1, 1'b0, 4'd0, 32'h0, 1'b0, W1,    1'b0, 32'd0, 16'd0, 1'b1, 1'b0};
    vt[9]  = '{1'b0, 1'b0, 4'd0, 32'h0, 1'b0, W0,    1'b1, 32'd4, 16'd0, 1'b1, 1'b0};
    vt[10] = '{1'b0, 1'b0, 4'd0, 32'h0, 1'b0, W0,    1'b1, 32'd4, 16'd0, 1'b1, 1'b0};
    vt[11] = '{1'b0, 1'b1, 4'd1, HALT,  1'b0, W0,    1'b1, 32'd4, 16'd0, 1'b1, 1'b0};
    vt[12] = '{1'b1, 1'b0, 4'd0, 32'h0, 1'b0, W0,    1'b1, 32'd4, 16'd0, 1'b1, 1'b0};
    vt[13] = '{1'b0, 1'b0, 4'd0, 32'h0, 1'b0, W0,    1'b1, 32'd4, 16'd0, 1'b1, 1'b0};
    vt[14] = '{1'b0, 1'b0, 4'd0, 32'h0, 1'b0, W0,    1'b1, 32'd4, 16'd0, 1'b1, 1'b0};
    vt[15] = '{1'b0, 1'b0, 4'd0, 32'h0, 1'b1, W1,    1'b1, 32'd8, 16'd1, 1'b1, 1'b0};
    vt[16] = '{1'b0, 1'b0, 4'd0, 32'h0, 1'b1, W1,    1'b0, 32'd8, 16'd2, 1'b0, 1'b1};
    vt[17] = '{1'b0, 1'b0, 4'd0, 32'h0, 1'b0, W1,    1'b0, 32'd8, 16'd2, 1'b0, 1'b0};

    RST          = 1'b1;
    bus.start    = 1'b0;
    bus.ld_en    = 1'b0;
    bus.ld_addr  = '0;
    bus.ld_data  = '0;
    bus.ready_in = 1'b0;
    repeat (2) step();
    chk_all("reset", 32'h0, 1'b0, 32'd0, 16'd0, 1'b0, 1'b0);
    RST = 1'b0;

    // Table: load, back-to-back run, then backpressure run.
    for (int i = 0; i < NV; i++) begin
      bus.start    = vt[i].start;
      bus.ld_en    = vt[i].ld_en;
      bus.ld_addr  = vt[i].ld_addr;
      bus.ld_data  = vt[i].ld_data;
      bus.ready_in = vt[i].ready;
      step();
      chk_all($sformatf("v%0d", i), vt[i].e_instr, vt[i].e_valid, vt[i].e_pc,
              vt[i].e_cnt, vt[i].e_busy, vt[i].e_done);
    end
    bus.start = 1'b0;
    bus.ld_en = 1'b0;

    // Empty program.
    load(4'd0, HALT);
    bus.ready_in = 1'b1;
    bus.start    = 1'b1;
    step();
    bus.start    = 1'b0;
    chk("empty.busy", 32'(bus.busy), 32'd1);
    chk("empty.valid0", 32'(bus.valid_out), 32'd0);
    step();
    chk("empty.done", 32'(bus.done), 32'd1);
    chk("empty.valid1", 32'(bus.valid_out), 32'd0);
    chk("empty.cnt", 32'(bus.instr_count), 32'd0);
    chk("empty.pc", bus.pc_out, 32'd0);
    step();
    chk("empty.done_off", 32'(bus.done), 32'd0);

    // Wrap-around: 16 non-halt words; a mid-run write of HALT to mem[0] is ignored.
    for (int k = 0; k < 16; k++) load(4'(k), 32'(k + 1));
    bus.ready_in = 1'b1;
    bus.start    = 1'b1;
    step();
    bus.start    = 1'b0;
    chk("wrap.busy", 32'(bus.busy), 32'd1);
    for (int k = 0; k < 16; k++) begin
      bus.ld_en   = (k == 2);
      bus.ld_addr = 4'd0;
      bus.ld_data = HALT;
      step();
      chk($sformatf("wrap.w%0d", k), bus.Instruccion_TR, 32'(k + 1));
      chk($sformatf("wrap.pc%0d", k), bus.pc_out, 32'(((k + 1) % 16) * 4));
    end
    bus.ld_en = 1'b0;
    step();
    chk("wrap.again", bus.Instruccion_TR, 32'd1);
    chk("wrap.again_pc", bus.pc_out, 32'd4);
    chk("wrap.cnt", 32'(bus.instr_count), 32'd16);
    chk("wrap.still_busy", 32'(bus.busy), 32'd1);

    // Asynchronous reset between edges clears outputs immediately.
    #3;
    RST = 1'b1;
    #1;
    chk_all("arst", 32'h0, 1'b0, 32'd0, 16'd0, 1'b0, 1'b0);
    step();
    RST = 1'b0;

    // Retained memory replays from mem[0]; end the run with HALT at mem[1].
    load(4'd1, HALT);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    chk_all("replay.w0", 32'd1, 1'b1, 32'd4, 16'd0, 1'b1, 1'b0);
    step();
    chk_all("replay.end", 32'd1, 1'b0, 32'd4, 16'd1, 1'b0, 1'b1);
    step();
    chk("replay.idle", 32'(bus.done), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
